// File: rtl/ysyx_22050854_imem_if.sv
// Fetch-side handshake bundle between the core (master) and the instruction
// memory responder (slave): request with pc, response with instruction/error.
interface ysyx_22050854_imem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/ysyx_22050854_imem_responder.sv
// Instruction-memory responder: word store loaded through a side port, answering
// fetches after a fixed number of wait states, flagging misaligned/out-of-range pcs.
module ysyx_22050854_imem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ysyx_22050854_imem_if.slave   bus,
    input  logic                  load_en_i,
    input  logic [DEPTH_LOG2-1:0] load_addr_i,
    input  logic [31:0]           load_data_i,
    output logic [31:0]           fetch_cnt_o
);
    localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           fetch_cnt_q, fetch_cnt_d;
    logic [31:0]           inst_q;
    logic                  err_q;
    logic                  enter_resp;

    logic [31:0]           rd_addr;
    logic [31:0]           rd_off;
    logic                  rd_err;
    logic [DEPTH_LOG2-1:0] rd_idx;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        fetch_cnt_d = fetch_cnt_q;
        enter_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d     = IDLE;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY==1 the read happens on the accepting edge, before addr_q holds the pc.
    always_comb begin
        rd_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_err  = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
        rd_idx  = rd_off[DEPTH_LOG2+1:2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            addr_q      <= 32'd0;
            fetch_cnt_q <= 32'd0;
            inst_q      <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            fetch_cnt_q <= fetch_cnt_d;
            if (enter_resp) begin
                err_q  <= rd_err;
                inst_q <= rd_err ? NOP : mem[rd_idx];
            end
        end
    end

    // Read-first: a load to the word captured on the same edge leaves the old data in inst_q.
    always_ff @(posedge clk_i) begin
        if (load_en_i && rst_ni) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_inst  = inst_q;
    assign bus.resp_err   = err_q;
    assign fetch_cnt_o    = fetch_cnt_q;
endmodule

// File: tb/tb_ysyx_22050854_imem_responder.sv
// Directed and randomized checks of the imem responder against a behavioural
// address/store model; one LATENCY=2 instance and one LATENCY=1 instance.
module tb_ysyx_22050854_imem_responder;
    localparam int          DLOG2 = 12;
    localparam int          DEPTH = 1 << DLOG2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050854_imem_if f ();
    ysyx_22050854_imem_if f1 ();

    logic             load_en, load1_en;
    logic [DLOG2-1:0] load_addr, load1_addr;
    logic [31:0]      load_data, load1_data;
    logic [31:0]      fetch_cnt, fetch1_cnt;

    ysyx_22050854_imem_responder #(.DEPTH_LOG2(DLOG2), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(f.slave),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
        .fetch_cnt_o(fetch_cnt)
    );

    ysyx_22050854_imem_responder #(.DEPTH_LOG2(DLOG2), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(f1.slave),
        .load_en_i(load1_en), .load_addr_i(load1_addr), .load_data_i(load1_data),
        .fetch_cnt_o(fetch1_cnt)
    );

    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_mem1 [DEPTH];
    logic [31:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural view: byte offset from BASE, word-aligned and inside the store, else nop+err.
    function automatic void model(input logic [31:0] a, input bit use1,
                                  output logic [31:0] inst, output logic err);
        logic [31:0] off;
        off = a - BASE;
        err = (a % 4 != 0) || (off >= 32'(4 * DEPTH));
        if (err)       inst = NOP;
        else if (use1) inst = ref_mem1[off / 4];
        else           inst = ref_mem[off / 4];
    endfunction

    task automatic load(input int idx, input logic [31:0] data);
        load_en = 1'b1; load_addr = DLOG2'(idx); load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic load1(input int idx, input logic [31:0] data);
        load1_en = 1'b1; load1_addr = DLOG2'(idx); load1_data = data;
        @(posedge clk); #1;
        load1_en = 1'b0;
        ref_mem1[idx] = data;
    endtask

    // Fetch on the LATENCY=2 instance, holding resp_ready low for 'hold' cycles of RESP.
    task automatic do_fetch(input logic [31:0] a, input int hold);
        logic [31:0] ei;
        logic        ee;
        int          n;
        model(a, 1'b0, ei, ee);
        chk("req_ready_idle", 32'(f.req_ready), 32'd1);
        f.req_valid = 1'b1; f.req_addr = a; f.resp_ready = (hold == 0);
        @(posedge clk); #1;
        f.req_valid = 1'b0; f.req_addr = $urandom;
        n = 1;
        while (!f.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        chk("resp_inst", f.resp_inst, ei);
        chk("resp_err", 32'(f.resp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(f.resp_valid), 32'd1);
            chk("bp_inst", f.resp_inst, ei);
            chk("bp_err", 32'(f.resp_err), 32'(ee));
            chk("bp_req_ready", 32'(f.req_ready), 32'd0);
        end
        f.resp_ready = 1'b1;
        @(posedge clk); #1;
        f.resp_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        $display("fetch addr=%h inst=%h err=%0d hold=%0d cnt=%0d", a, f.resp_inst, f.resp_err, hold, fetch_cnt);
        chk("valid_drop", 32'(f.resp_valid), 32'd0);
        chk("ready_back", 32'(f.req_ready), 32'd1);
        chk("fetch_cnt", fetch_cnt, exp_cnt);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] ei;
        logic        ee;
        int          kind;

        rst_n = 1'b0;
        f.req_valid = 1'b0; f.req_addr = 32'd0; f.resp_ready = 1'b0;
        f1.req_valid = 1'b0; f1.req_addr = 32'd0; f1.resp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = 32'd0;
        load1_en = 1'b0; load1_addr = '0; load1_data = 32'd0;
        exp_cnt = 32'd0;
        #1;
        chk("rst_req_ready", 32'(f.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(f.resp_valid), 32'd0);
        chk("rst_resp_inst", f.resp_inst, 32'd0);
        chk("rst_resp_err", 32'(f.resp_err), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic program fetch.
        load(0, 32'h0010_0093);
        load(1, 32'h0000_0073);
        load(3, 32'hAAAA_AAAA);
        do_fetch(BASE, 0);
        do_fetch(BASE + 32'd4, 0);
        chk("cnt_after_two", fetch_cnt, 32'd2);

        // Error responses: misaligned, past the end, below base.
        do_fetch(32'h8000_0002, 0);
        do_fetch(32'h8000_4000, 0);
        do_fetch(32'h7FFF_FFFC, 0);
        chk("cnt_after_err", fetch_cnt, 32'd5);

        // Backpressure.
        do_fetch(BASE + 32'd4, 5);

        // Load race on the edge entering RESP.
        f.req_valid = 1'b1; f.req_addr = BASE + 32'd12; f.resp_ready = 1'b0;
        @(posedge clk); #1;
        f.req_valid = 1'b0;
        load_en = 1'b1; load_addr = DLOG2'(3); load_data = 32'h5555_5555;
        @(posedge clk); #1;
        load_en = 1'b0;
        chk("race_valid", 32'(f.resp_valid), 32'd1);
        chk("race_inst", f.resp_inst, 32'hAAAA_AAAA);
        ref_mem[3] = 32'h5555_5555;
        @(posedge clk); #1;
        chk("race_hold_inst", f.resp_inst, 32'hAAAA_AAAA);
        f.resp_ready = 1'b1;
        @(posedge clk); #1;
        f.resp_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        $display("race inst=%h cnt=%0d", 32'hAAAA_AAAA, fetch_cnt);
        chk("race_cnt", fetch_cnt, exp_cnt);
        do_fetch(BASE + 32'd12, 0);

        // Randomized fetches over a loaded window plus error addresses.
        load(2, $urandom);
        for (int i = 4; i < 16; i++) load(i, $urandom);
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            a = BASE + 32'(4 * $urandom_range(0, 15));
            if (kind == 2) a = a + 32'($urandom_range(1, 3));
            if (kind == 3) a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 4095));
            if (kind == 4) a = BASE - 32'(4 * $urandom_range(1, 4096));
            do_fetch(a, $urandom_range(0, 3));
        end

        // Asynchronous reset during WAIT; loads during reset are ignored.
        f.req_valid = 1'b1; f.req_addr = BASE; f.resp_ready = 1'b1;
        @(posedge clk); #1;
        f.req_valid = 1'b0;
        chk("pre_rst_waiting", 32'(f.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", 32'(f.resp_valid), 32'd0);
        chk("arst_req_ready", 32'(f.req_ready), 32'd1);
        chk("arst_fetch_cnt", fetch_cnt, 32'd0);
        load_en = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        @(posedge clk); #1;
        $display("reset mid-WAIT released cnt=%0d", fetch_cnt);
        do_fetch(BASE, 0);

        // LATENCY=1 instance: one acceptance every second cycle with resp_ready held.
        for (int i = 0; i < 4; i++) load1(i, $urandom);
        f1.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = BASE + 32'(4 * i);
            model(a, 1'b1, ei, ee);
            f1.req_valid = 1'b1; f1.req_addr = a;
            chk("l1_req_ready", 32'(f1.req_ready), 32'd1);
            chk("l1_idle_valid", 32'(f1.resp_valid), 32'd0);
            @(posedge clk); #1;
            chk("l1_resp_valid", 32'(f1.resp_valid), 32'd1);
            chk("l1_busy", 32'(f1.req_ready), 32'd0);
            chk("l1_inst", f1.resp_inst, ei);
            chk("l1_err", 32'(f1.resp_err), 32'(ee));
            $display("lat1 fetch addr=%h inst=%h err=%0d", a, f1.resp_inst, f1.resp_err);
            @(posedge clk); #1;
        end
        f1.req_valid = 1'b0;
        f1.resp_ready = 1'b0;
        chk("l1_fetch_cnt", fetch1_cnt, 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
